// File: rtl/controle_turnos.sv
`default_nettype none
// ============================================================================
// Module      : controle_turnos
// Description : Turn controller for a two-board naval battle game. Walks
//               the shooter through coordinate entry (or draws a random shot
//               on the CPU's turn), runs a request/ack lookup against the
//               opponent's board memory, scores hits and declares a winner.
// Ports       : clk, reset            - clock, synchronous active-high reset
//               start, mode           - game enable level, 0=vs CPU 1=2P
//               enter, select         - active-low pushbuttons (synchronized)
//               mem_req/mem_jogador/X/Y - shot lookup request and coordinate
//               mem_ack/mem_resultado - lookup reply (00 water, 01 hit, 1x shot)
//               jogador_atual, acertos0/1, fim_jogo, vencedor - game status
//               erro                  - one-cycle pulse on lookup timeout
//               estado                - FSM state code for the display
// Revision    : 1.0 - initial release
// ============================================================================
module controle_turnos #(
  parameter int TOTAL_CELULAS = 24,
  parameter int TIMEOUT       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       enter,
  input  logic       select,
  input  logic       mode,
  input  logic       mem_ack,
  input  logic [1:0] mem_resultado,
  output logic       mem_req,
  output logic       mem_jogador,
  output logic [3:0] X,
  output logic [3:0] Y,
  output logic       jogador_atual,
  output logic [4:0] acertos0,
  output logic [4:0] acertos1,
  output logic       fim_jogo,
  output logic       vencedor,
  output logic       erro,
  output logic [2:0] estado
);

  localparam int              TW         = $clog2(TIMEOUT + 1);
  localparam logic [4:0]      TOTAL      = 5'(TOTAL_CELULAS);
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEFINE_X = 3'd1,
    DEFINE_Y = 3'd2,
    DISPARO  = 3'd3,
    AGUARDA  = 3'd4,
    AVALIA   = 3'd5,
    TROCA    = 3'd6,
    FIM      = 3'd7
  } state_t;

  state_t        state, state_next;
  logic          enter_prev, select_prev;
  logic          enter_ev, select_ev;
  logic          modo_pvp;
  logic [1:0]    resultado;
  logic [TW-1:0] timer;
  logic [7:0]    lfsr;
  logic [3:0]    rand_x, rand_y;
  logic          cpu_atual, cpu_outro;
  logic [4:0]    placar;

  logic start_game, inc_x, inc_y, load_rand, clear_xy, latch_res;
  logic clear_timer, count_hit, set_vencedor, toggle_player, erro_next;

  // Folds a 0..15 nibble onto 0..9 so random shots land on the board.
  function automatic logic [3:0] dobra(input logic [3:0] n);
    return (n > 4'd9) ? n - 4'd6 : n;
  endfunction

  assign enter_ev  = enter_prev & ~enter;
  assign select_ev = select_prev & ~select;
  assign rand_x    = dobra(lfsr[7:4]);
  assign rand_y    = dobra(lfsr[3:0]);
  assign cpu_atual = ~modo_pvp & jogador_atual;
  assign cpu_outro = ~modo_pvp & ~jogador_atual;
  assign placar    = jogador_atual ? acertos1 : acertos0;

  assign mem_req     = (state == DISPARO);
  assign mem_jogador = ~jogador_atual;
  assign fim_jogo    = (state == FIM);
  assign estado      = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    start_game    = 1'b0;
    inc_x         = 1'b0;
    inc_y         = 1'b0;
    load_rand     = 1'b0;
    clear_xy      = 1'b0;
    latch_res     = 1'b0;
    clear_timer   = 1'b0;
    count_hit     = 1'b0;
    set_vencedor  = 1'b0;
    toggle_player = 1'b0;
    erro_next     = 1'b0;
    // Dropping start abandons the turn; the finished game stays put.
    if (!start && state != IDLE && state != FIM) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          state_next = DEFINE_X;
          start_game = 1'b1;
        end
        DEFINE_X: begin
          inc_x = select_ev;
          if (enter_ev) state_next = DEFINE_Y;
        end
        DEFINE_Y: begin
          inc_y = select_ev;
          if (enter_ev) state_next = DISPARO;
        end
        DISPARO: begin
          clear_timer = 1'b1;
          state_next  = AGUARDA;
        end
        AGUARDA: begin
          if (mem_ack) begin
            latch_res  = 1'b1;
            state_next = AVALIA;
          end else if (timer == TIMER_LAST) begin
            erro_next  = 1'b1;
            load_rand  = cpu_atual;
            state_next = cpu_atual ? DISPARO : DEFINE_X;
          end
        end
        AVALIA: begin
          case (resultado)
            2'b01: begin
              count_hit = 1'b1;
              if (placar + 5'd1 == TOTAL) begin
                set_vencedor = 1'b1;
                state_next   = FIM;
              end else begin
                load_rand  = cpu_atual;
                state_next = cpu_atual ? DISPARO : DEFINE_X;
              end
            end
            2'b00:   state_next = TROCA;
            default: begin
              load_rand  = cpu_atual;
              state_next = cpu_atual ? DISPARO : DEFINE_X;
            end
          endcase
        end
        TROCA: begin
          // The turn passes to the other player, who may be the CPU.
          toggle_player = 1'b1;
          load_rand     = cpu_outro;
          clear_xy      = ~cpu_outro;
          state_next    = cpu_outro ? DISPARO : DEFINE_X;
        end
        FIM: state_next = FIM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      X             <= 4'd0;
      Y             <= 4'd0;
      jogador_atual <= 1'b0;
      acertos0      <= 5'd0;
      acertos1      <= 5'd0;
      vencedor      <= 1'b0;
      erro          <= 1'b0;
      lfsr          <= 8'h01;
      enter_prev    <= 1'b1;
      select_prev   <= 1'b1;
      modo_pvp      <= 1'b0;
      resultado     <= 2'b00;
      timer         <= '0;
    end else begin
      enter_prev  <= enter;
      select_prev <= select;
      erro        <= erro_next;
      // Free-running Fibonacci LFSR, taps 8,6,5,4.
      lfsr        <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

      if (start_game) begin
        modo_pvp      <= mode;
        jogador_atual <= 1'b0;
        acertos0      <= 5'd0;
        acertos1      <= 5'd0;
      end
      if (toggle_player) jogador_atual <= ~jogador_atual;

      if (start_game || clear_xy) begin
        X <= 4'd0;
        Y <= 4'd0;
      end else if (load_rand) begin
        X <= rand_x;
        Y <= rand_y;
      end else begin
        if (inc_x) X <= (X == 4'd9) ? 4'd0 : X + 4'd1;
        if (inc_y) Y <= (Y == 4'd9) ? 4'd0 : Y + 4'd1;
      end

      if (latch_res)   resultado <= mem_resultado;
      if (clear_timer) timer <= '0;
      else if (state == AGUARDA) timer <= timer + 1'b1;

      if (count_hit) begin
        if (!jogador_atual && acertos0 != TOTAL) acertos0 <= acertos0 + 5'd1;
        if (jogador_atual && acertos1 != TOTAL)  acertos1 <= acertos1 + 5'd1;
      end
      if (set_vencedor) vencedor <= jogador_atual;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_controle_turnos.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_turnos
// Description : Self-checking bench for controle_turnos. Stimulus queues the
//               expected shot coordinate for every lookup it provokes; a
//               monitor pops and compares on every mem_req cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_turnos;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       enter = 1'b1;
  logic       select = 1'b1;
  logic       mode = 1'b0;
  logic       mem_ack = 1'b0;
  logic [1:0] mem_resultado = 2'b00;
  logic       mem_req, mem_jogador, jogador_atual, fim_jogo, vencedor, erro;
  logic [3:0] X, Y;
  logic [4:0] acertos0, acertos1;
  logic [2:0] estado;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       jog;
    logic       cpu;
  } shot_t;

  shot_t exp_q[$];
  shot_t mon_e;

  controle_turnos #(.TOTAL_CELULAS(24), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .enter(enter), .select(select),
    .mode(mode), .mem_ack(mem_ack), .mem_resultado(mem_resultado),
    .mem_req(mem_req), .mem_jogador(mem_jogador), .X(X), .Y(Y),
    .jogador_atual(jogador_atual), .acertos0(acertos0), .acertos1(acertos1),
    .fim_jogo(fim_jogo), .vencedor(vencedor), .erro(erro), .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Monitor: every lookup request must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mem_req) begin
      if (exp_q.size() == 0) begin
        check("unexpected_mem_req", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cpu) begin
          check("cpu_x_in_range", int'(X <= 4'd9), 1);
          check("cpu_y_in_range", int'(Y <= 4'd9), 1);
        end else begin
          check("shot_x", X, mon_e.x);
          check("shot_y", Y, mon_e.y);
        end
        check("shot_mem_jogador", mem_jogador, mon_e.jog);
      end
    end
  end

  task automatic expect_shot(input int x, input int y, input int jog, input int cpu);
    shot_t s;
    s.x = 4'(x); s.y = 4'(y); s.jog = 1'(jog); s.cpu = 1'(cpu);
    exp_q.push_back(s);
  endtask

  task automatic press_select();
    @(posedge clk); #1 select = 1'b0;
    @(posedge clk); #1 select = 1'b1;
  endtask

  task automatic press_enter();
    @(posedge clk); #1 enter = 1'b0;
    @(posedge clk); #1 enter = 1'b1;
  endtask

  task automatic shot(input int nx, input int ny);
    for (int i = 0; i < nx; i++) press_select();
    press_enter();
    for (int i = 0; i < ny; i++) press_select();
    press_enter();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 100);
    if (!mem_req) check("mem_req_seen", 0, 1);
  endtask

  task automatic reply(input logic [1:0] r);
    @(posedge clk); #1 mem_ack = 1'b1; mem_resultado = r;
    @(posedge clk); #1 mem_ack = 1'b0; mem_resultado = 2'b00;
  endtask

  initial begin
    int k;
    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_estado", estado, 0);
    check("rst_x", X, 0);
    check("rst_y", Y, 0);
    check("rst_jogador", jogador_atual, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_acertos0", acertos0, 0);
    check("rst_acertos1", acertos1, 0);
    check("rst_fim", fim_jogo, 0);
    check("rst_erro", erro, 0);
    check("rst_mem_jogador", mem_jogador, 1);

    // Two-player game: first shot at (3,2)
    @(posedge clk); #1 start = 1'b1; mode = 1'b1;
    wait_cycles(2);
    check("start_define_x", estado, 1);
    expect_shot(3, 2, 1, 0);
    shot(3, 2);
    wait_req();
    reply(2'b01);
    wait_cycles(3);
    check("hit_acertos0", acertos0, 1);
    check("hit_same_player", jogador_atual, 0);
    check("hit_back_to_x", estado, 1);

    // Same coordinate again, water: turn passes to player 1
    expect_shot(3, 2, 1, 0);
    shot(0, 0);
    wait_req();
    reply(2'b00);
    wait_cycles(3);
    check("water_player", jogador_atual, 1);
    check("water_x_clear", X, 0);
    check("water_y_clear", Y, 0);
    check("water_acertos0", acertos0, 1);

    // X wraps after 10 selects
    for (int i = 0; i < 10; i++) press_select();
    wait_cycles(1);
    check("x_wrap", X, 0);
    expect_shot(4, 7, 0, 0);
    shot(4, 7);
    wait_req();
    reply(2'b10);
    wait_cycles(3);
    check("shot_again_player", jogador_atual, 1);
    check("shot_again_acertos1", acertos1, 0);
    check("shot_again_estado", estado, 1);

    // Timeout: no ack at all
    expect_shot(4, 7, 0, 0);
    shot(0, 0);
    wait_req();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!erro && k < 40);
    check("timeout_erro_seen", erro, 1);
    check("timeout_latency", k, 17);
    check("timeout_estado", estado, 1);
    check("timeout_player", jogador_atual, 1);
    @(negedge clk);
    check("erro_one_cycle", erro, 0);

    // 24 hits for player 1 end the game
    for (int i = 0; i < 24; i++) begin
      expect_shot(4, 7, 0, 0);
      shot(0, 0);
      wait_req();
      reply(2'b01);
      wait_cycles(3);
      if (i == 22) begin
        check("acertos1_23", acertos1, 23);
        check("not_over_at_23", fim_jogo, 0);
      end
    end
    check("final_acertos1", acertos1, 24);
    check("final_fim", fim_jogo, 1);
    check("final_vencedor", vencedor, 1);
    check("final_estado", estado, 7);
    press_select();
    press_enter();
    press_enter();
    wait_cycles(3);
    check("fim_hold_estado", estado, 7);
    check("fim_hold_x", X, 4);
    check("fim_hold_fim", fim_jogo, 1);

    // Player vs CPU
    @(posedge clk); #1 reset = 1'b1; start = 1'b0; mode = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    wait_cycles(2);
    expect_shot(1, 1, 1, 0);
    shot(1, 1);
    wait_req();
    reply(2'b01);
    wait_cycles(3);
    check("cpu_game_acertos0", acertos0, 1);
    expect_shot(1, 1, 1, 0);
    expect_shot(0, 0, 0, 1);
    shot(0, 0);
    wait_req();
    reply(2'b00);
    wait_req();
    check("cpu_player", jogador_atual, 1);
    @(negedge clk);
    check("cpu_aguarda", estado, 4);
    @(posedge clk); #1 reset = 1'b1; start = 1'b0; mem_ack = 1'b1; mem_resultado = 2'b01;
    @(posedge clk); #1 reset = 1'b0; mem_ack = 1'b0; mem_resultado = 2'b00;
    @(negedge clk);
    check("mid_rst_estado", estado, 0);
    check("mid_rst_x", X, 0);
    check("mid_rst_y", Y, 0);
    check("mid_rst_player", jogador_atual, 0);
    check("mid_rst_mem_req", mem_req, 0);
    check("mid_rst_acertos0", acertos0, 0);
    check("mid_rst_fim", fim_jogo, 0);
    check("mid_rst_vencedor", vencedor, 0);
    check("mid_rst_erro", erro, 0);

    // Late ack in IDLE is ignored
    @(posedge clk); #1 mem_ack = 1'b1; mem_resultado = 2'b01;
    @(posedge clk); #1 mem_ack = 1'b0; mem_resultado = 2'b00;
    wait_cycles(3);
    check("late_ack_idle", estado, 0);
    check("late_ack_acertos0", acertos0, 0);

    check("pending_shots", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
